// File: rtl/bit_stream_packer.sv
// Packs a variable-width, LSB-first chunk stream into WIDTH-bit words and emits
// each full word, or the zero-padded tail of a packet, as a one-cycle pulse.
module bit_stream_packer #(
   parameter int WIDTH = 128,
   parameter int IN_W  = 16
) (
   input  logic                 clk_i,
   input  logic                 srst_i,
   input  logic [IN_W-1:0]      data_i,
   input  logic [$clog2(IN_W):0] data_mod_i,
   input  logic                 data_last_i,
   input  logic                 data_val_i,
   output logic                 ready_o,
   output logic [WIDTH-1:0]     data_o,
   output logic                 data_val_o,
   output logic                 data_last_o
);

   localparam int MOD_W  = $clog2(IN_W) + 1;
   localparam int FILL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TOT_W  = $clog2(2 * WIDTH) + 1;

   typedef enum logic {
      ACC   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t              state_q;
   logic [WIDTH-1:0]    buf_q;
   logic [FILL_W-1:0]   fill_q;
   logic [WIDTH-1:0]    data_q;
   logic                data_val_q;
   logic                data_last_q;

   logic [MOD_W-1:0]    n;
   logic [IN_W-1:0]     mask;
   logic [IN_W-1:0]     masked;
   logic [2*WIDTH-1:0]  merged;
   logic [TOT_W-1:0]    total;
   logic                accept;

   assign ready_o     = (state_q == ACC);
   assign accept      = data_val_i && ready_o;
   assign data_o      = data_q;
   assign data_val_o  = data_val_q;
   assign data_last_o = data_last_q;

   // NOTE: blocking assignments in combinational logic, and every output gets a
   // value on every path so no latch is inferred.
   always_comb begin
      n      = (data_mod_i > MOD_W'(IN_W)) ? MOD_W'(IN_W) : data_mod_i;
      mask   = ~({IN_W{1'b1}} << n);
      masked = data_i & mask;
      // buf_q is always zero above fill_q, so the OR never collides with live bits
      merged = {{WIDTH{1'b0}}, buf_q} | ({{(2*WIDTH-IN_W){1'b0}}, masked} << fill_q);
      total  = TOT_W'(fill_q) + TOT_W'(n);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q     <= ACC;
         buf_q       <= '0;
         fill_q      <= '0;
         data_q      <= '0;
         data_val_q  <= 1'b0;
         data_last_q <= 1'b0;
      end else begin
         data_val_q <= 1'b0;
         case (state_q)
            ACC: begin
               if (accept) begin
                  if (!data_last_i) begin
                     if (total >= TOT_W'(WIDTH)) begin
                        data_q      <= merged[WIDTH-1:0];
                        data_val_q  <= 1'b1;
                        data_last_q <= 1'b0;
                        buf_q       <= merged[2*WIDTH-1:WIDTH];
                        fill_q      <= FILL_W'(total - TOT_W'(WIDTH));
                     end else begin
                        buf_q  <= merged[WIDTH-1:0];
                        fill_q <= FILL_W'(total);
                     end
                  end else if (total > TOT_W'(WIDTH)) begin
                     // Packet end straddles a word boundary: tail goes out next cycle
                     data_q      <= merged[WIDTH-1:0];
                     data_val_q  <= 1'b1;
                     data_last_q <= 1'b0;
                     buf_q       <= merged[2*WIDTH-1:WIDTH];
                     fill_q      <= FILL_W'(total - TOT_W'(WIDTH));
                     state_q     <= FLUSH;
                  end else if (total != '0) begin
                     data_q      <= merged[WIDTH-1:0];
                     data_val_q  <= 1'b1;
                     data_last_q <= 1'b1;
                     buf_q       <= '0;
                     fill_q      <= '0;
                  end
               end
            end
            FLUSH: begin
               data_q      <= buf_q;
               data_val_q  <= 1'b1;
               data_last_q <= 1'b1;
               buf_q       <= '0;
               fill_q      <= '0;
               state_q     <= ACC;
            end
            default: state_q <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer: a vector table for the main packing
// cases plus hand-written reset sequences.
module tb_bit_stream_packer;

   localparam int WIDTH = 128;
   localparam int IN_W  = 16;
   localparam int MOD_W = $clog2(IN_W) + 1;

   logic              clk_i = 1'b0;
   logic              srst_i;
   logic [IN_W-1:0]   data_i;
   logic [MOD_W-1:0]  data_mod_i;
   logic              data_last_i;
   logic              data_val_i;
   logic              ready_o;
   logic [WIDTH-1:0]  data_o;
   logic              data_val_o;
   logic              data_last_o;

   int n_checks = 0;
   int n_pass   = 0;

   bit_stream_packer #(.WIDTH(WIDTH), .IN_W(IN_W)) dut (
      .clk_i      (clk_i),
      .srst_i     (srst_i),
      .data_i     (data_i),
      .data_mod_i (data_mod_i),
      .data_last_i(data_last_i),
      .data_val_i (data_val_i),
      .ready_o    (ready_o),
      .data_o     (data_o),
      .data_val_o (data_val_o),
      .data_last_o(data_last_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string            tag;
      logic [IN_W-1:0]  d;
      logic [MOD_W-1:0] mod;
      logic             last;
      logic             val;
      logic             exp_ready;
      logic             exp_val;
      logic             exp_last;
      logic [WIDTH-1:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void add(input string tag, input logic [IN_W-1:0] d,
                               input logic [MOD_W-1:0] mod, input logic last,
                               input logic val, input logic exp_ready,
                               input logic exp_val, input logic exp_last,
                               input logic [WIDTH-1:0] exp_data);
      vec_t v;
      v.tag = tag; v.d = d; v.mod = mod; v.last = last; v.val = val;
      v.exp_ready = exp_ready; v.exp_val = exp_val; v.exp_last = exp_last;
      v.exp_data = exp_data;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic [IN_W-1:0] d, input logic [MOD_W-1:0] mod,
                        input logic last, input logic val);
      data_i = d; data_mod_i = mod; data_last_i = last; data_val_i = val;
   endtask

   // Inputs are applied away from the edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] ones;
      ones = '1;

      srst_i = 1'b1;
      drive('0, '0, 1'b0, 1'b0);
      repeat (2) step();
      check("reset data_o", data_o, '0);
      check("reset data_val_o", WIDTH'(data_val_o), '0);
      check("reset data_last_o", WIDTH'(data_last_o), '0);
      check("reset ready_o", WIDTH'(ready_o), WIDTH'(1));
      srst_i = 1'b0;

      // 8 x 0xFFFF, last on beat 8: one all-ones word with last
      for (int i = 0; i < 7; i++) add("ones_beat", 16'hFFFF, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      add("ones_last", 16'hFFFF, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ones);
      // 3 x 0xAAAA, last on beat 3: zero-padded partial word
      add("aaaa_b1", 16'hAAAA, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      add("aaaa_b2", 16'hAAAA, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      add("aaaa_last", 16'hAAAA, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'hAAAA_AAAA_AAAA);
      add("idle", 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      // 13 x 0x3FF mod 10 = 130 bits: full word, one FLUSH bubble, tail 0x3
      for (int i = 0; i < 12; i++) add("ten_beat", 16'h03FF, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      add("ten_last", 16'h03FF, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ones);
      add("flush_hold", 16'h1234, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'h3);
      add("held_accept", 16'h1234, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'h1234);
      // Masking and clamping
      add("mask_mod4", 16'hFFFF, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'hF);
      add("clamp_mod31", 16'h8001, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'h8001);
      // Empty last beat with nothing buffered emits nothing
      add("empty_last", 16'hFFFF, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      // Empty last beat with pending bits flushes them in place
      add("ff_beat", 16'h00FF, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      add("mod0_last", 16'hFFFF, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'hFF);
      // Exactly WIDTH bits without last: word goes out with last=0
      for (int i = 0; i < 7; i++) add("exact_beat", 16'h0F0F, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      add("exact_word", 16'h0F0F, 5'd16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {8{16'h0F0F}});
      add("after_exact", 16'h0005, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 128'h5);

      foreach (vecs[i]) begin
         drive(vecs[i].d, vecs[i].mod, vecs[i].last, vecs[i].val);
         step();
         check({vecs[i].tag, " val"}, WIDTH'(data_val_o), WIDTH'(vecs[i].exp_val));
         check({vecs[i].tag, " ready"}, WIDTH'(ready_o), WIDTH'(vecs[i].exp_ready));
         if (vecs[i].exp_val) begin
            check({vecs[i].tag, " data"}, data_o, vecs[i].exp_data);
            check({vecs[i].tag, " last"}, WIDTH'(data_last_o), WIDTH'(vecs[i].exp_last));
         end
         if (vecs[i].tag == "ones_last")
            check("ones popcount", WIDTH'($countones(data_o)), WIDTH'(128));
         if (vecs[i].tag == "aaaa_last")
            check("aaaa popcount", WIDTH'($countones(data_o)), WIDTH'(24));
      end

      // Reset while in FLUSH discards the tail
      for (int i = 0; i < 12; i++) begin
         drive(16'h03FF, 5'd10, 1'b0, 1'b1);
         step();
      end
      drive(16'h03FF, 5'd10, 1'b1, 1'b1);
      step();
      check("rst_flush enter val", WIDTH'(data_val_o), WIDTH'(1));
      check("rst_flush enter ready", WIDTH'(ready_o), '0);
      srst_i = 1'b1;
      drive('0, '0, 1'b0, 1'b0);
      step();
      check("rst_flush no word", WIDTH'(data_val_o), '0);
      check("rst_flush ready", WIDTH'(ready_o), WIDTH'(1));
      srst_i = 1'b0;
      step();
      check("post_rst idle val", WIDTH'(data_val_o), '0);
      drive(16'h0001, 5'd1, 1'b1, 1'b1);
      step();
      check("fresh val", WIDTH'(data_val_o), WIDTH'(1));
      check("fresh data", data_o, 128'h1);
      check("fresh last", WIDTH'(data_last_o), WIDTH'(1));

      // Reset mid-packet drops the partial buffer
      drive(16'h00FF, 5'd8, 1'b0, 1'b1);
      step();
      srst_i = 1'b1;
      drive('0, '0, 1'b0, 1'b0);
      step();
      check("rst_mid no word", WIDTH'(data_val_o), '0);
      srst_i = 1'b0;
      drive(16'h0003, 5'd2, 1'b1, 1'b1);
      step();
      check("rst_mid val", WIDTH'(data_val_o), WIDTH'(1));
      check("rst_mid data", data_o, 128'h3);

      drive('0, '0, 1'b0, 1'b0);
      step();
      check("final idle val", WIDTH'(data_val_o), '0);
      check("final hold data", data_o, 128'h3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
